// File: rtl/fs_accel_mem_arbiter.sv
// Purpose: arbitrates the single native memory port between the RDATA read stream and the WBACK write stream.
// Latency: grant visible 1 cycle after request, ready pulse 1 cycle after mem_ready, 3 cycles minimum per transfer.
// Backpressure: holds the bus registers stable until mem_ready; writes win unless MAX_WR_RUN consecutive writes have starved a read.
module fs_accel_mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MAX_WR_RUN = 4
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                enb,
  input  logic                rd_req,
  input  logic [ADDR_W-1:0]   rd_addr,
  output logic                rd_ready,
  output logic [DATA_W-1:0]   rd_data,
  input  logic                wr_req,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic [DATA_W/8-1:0] wr_strb,
  output logic                wr_ready,
  output logic                mem_valid,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb,
  input  logic                mem_ready,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                busy,
  output logic [1:0]          owner
);

  localparam int STRB_W = DATA_W / 8;
  localparam logic [3:0] MAX_RUN = 4'(MAX_WR_RUN);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RD_BUS = 2'd1,
    WR_BUS = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t              state_q;
  logic                mem_valid_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [DATA_W-1:0]   mem_wdata_q;
  logic [STRB_W-1:0]   mem_wstrb_q;
  logic                rd_ready_q;
  logic [DATA_W-1:0]   rd_data_q;
  logic                wr_ready_q;
  logic                busy_q;
  logic [1:0]          owner_q;
  logic [3:0]          wr_run_q;

  logic                grant_wr_d;
  logic [3:0]          wr_run_inc_d;

  // Write wins unless a waiting read has already been passed over MAX_WR_RUN times.
  always_comb begin
    grant_wr_d   = wr_req && (!rd_req || (wr_run_q < MAX_RUN));
    wr_run_inc_d = (wr_run_q >= MAX_RUN) ? MAX_RUN : (wr_run_q + 4'd1);
  end

  // Single-process FSM with every output registered; reset kills an in-flight transfer with no ready pulse.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      mem_valid_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= '0;
      rd_ready_q  <= 1'b0;
      rd_data_q   <= '0;
      wr_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      owner_q     <= 2'b00;
      wr_run_q    <= 4'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (enb && (rd_req || wr_req)) begin
            mem_valid_q <= 1'b1;
            busy_q      <= 1'b1;
            if (grant_wr_d) begin
              mem_addr_q  <= wr_addr;
              mem_wdata_q <= wr_data;
              mem_wstrb_q <= wr_strb;
              owner_q     <= 2'b10;
              state_q     <= WR_BUS;
              // Only count writes that actually made a read wait.
              wr_run_q    <= rd_req ? wr_run_inc_d : 4'd0;
            end else begin
              mem_addr_q  <= rd_addr;
              mem_wdata_q <= '0;
              mem_wstrb_q <= '0;
              owner_q     <= 2'b01;
              state_q     <= RD_BUS;
              wr_run_q    <= 4'd0;
            end
          end
        end
        RD_BUS: begin
          if (mem_ready) begin
            mem_valid_q <= 1'b0;
            owner_q     <= 2'b00;
            rd_ready_q  <= 1'b1;
            rd_data_q   <= mem_rdata;
            state_q     <= DONE;
          end
        end
        WR_BUS: begin
          if (mem_ready) begin
            mem_valid_q <= 1'b0;
            owner_q     <= 2'b00;
            wr_ready_q  <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          // Gap cycle lets the requester lower or advance its request before the next arbitration.
          rd_ready_q <= 1'b0;
          wr_ready_q <= 1'b0;
          busy_q     <= 1'b0;
          state_q    <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign mem_valid = mem_valid_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wstrb = mem_wstrb_q;
  assign rd_ready  = rd_ready_q;
  assign rd_data   = rd_data_q;
  assign wr_ready  = wr_ready_q;
  assign busy      = busy_q;
  assign owner     = owner_q;

endmodule

// File: tb/tb_fs_accel_mem_arbiter.sv
// Purpose: directed self-checking bench for fs_accel_mem_arbiter (MAX_WR_RUN=2).
// Latency: inputs driven 1 ns after a rising edge, outputs checked at the same point after the next edge.
// Backpressure: stalls are produced by holding mem_ready low for a fixed number of cycles.
module tb_fs_accel_mem_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  logic              clk;
  logic              resetn;
  logic              enb;
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_ready;
  logic [DATA_W-1:0] rd_data;
  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [3:0]        wr_strb;
  logic              wr_ready;
  logic              mem_valid;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [3:0]        mem_wstrb;
  logic              mem_ready;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;
  logic [1:0]        owner;

  int checks = 0;
  int errors = 0;

  fs_accel_mem_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WR_RUN(2)
  ) dut (
    .clk(clk), .resetn(resetn), .enb(enb),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ready(rd_ready), .rd_data(rd_data),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_strb(wr_strb), .wr_ready(wr_ready),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata), .busy(busy), .owner(owner)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    resetn = 1'b0; enb = 1'b0; rd_req = 1'b0; wr_req = 1'b0;
    rd_addr = '0; wr_addr = '0; wr_data = '0; wr_strb = '0;
    mem_ready = 1'b0; mem_rdata = '0;
    tick(); tick();
    checks++; if ({mem_valid, owner, busy, rd_ready, wr_ready} !== 6'b0) begin errors++; $display("FAIL reset_ctrl: got %b expected 000000", {mem_valid, owner, busy, rd_ready, wr_ready}); end
    checks++; if ({mem_addr, mem_wdata, mem_wstrb, rd_data} !== '0) begin errors++; $display("FAIL reset_data: got %h %h %h %h expected all zero", mem_addr, mem_wdata, mem_wstrb, rd_data); end
    checks++; if (dut.wr_run_q !== 4'd0) begin errors++; $display("FAIL reset_wr_run: got %0d expected 0", dut.wr_run_q); end
    @(negedge clk); resetn = 1'b1;
    tick();
    checks++; if ({mem_valid, busy} !== 2'b00) begin errors++; $display("FAIL reset_idle: got %b expected 00", {mem_valid, busy}); end
  endtask

  task automatic test_single_read();
    enb = 1'b1; rd_req = 1'b1; rd_addr = 32'h0000_1000;
    tick();
    checks++; if ({mem_valid, owner, busy} !== 4'b1011) begin errors++; $display("FAIL rd_grant: got %b expected 1011", {mem_valid, owner, busy}); end
    checks++; if (mem_addr !== 32'h0000_1000 || mem_wstrb !== 4'h0) begin errors++; $display("FAIL rd_bus: got addr %h strb %h expected 00001000 0", mem_addr, mem_wstrb); end
    tick();
    checks++; if ({mem_valid, rd_ready} !== 2'b10) begin errors++; $display("FAIL rd_wait: got %b expected 10", {mem_valid, rd_ready}); end
    mem_ready = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    tick();
    checks++; if ({rd_ready, wr_ready, mem_valid, owner, busy} !== 6'b100001) begin errors++; $display("FAIL rd_pulse: got %b expected 100001", {rd_ready, wr_ready, mem_valid, owner, busy}); end
    checks++; if (rd_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rd_data: got %h expected deadbeef", rd_data); end
    mem_ready = 1'b0; mem_rdata = 32'h0; rd_req = 1'b0;
    tick();
    checks++; if ({rd_ready, busy, mem_valid} !== 3'b000) begin errors++; $display("FAIL rd_done: got %b expected 000", {rd_ready, busy, mem_valid}); end
    checks++; if (rd_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rd_data_hold: got %h expected deadbeef", rd_data); end
  endtask

  task automatic test_single_write();
    wr_req = 1'b1; wr_addr = 32'h0000_2000; wr_data = 32'h1234_5678; wr_strb = 4'hF;
    tick();
    checks++; if ({mem_valid, owner, busy} !== 4'b1101) begin errors++; $display("FAIL wr_grant: got %b expected 1101", {mem_valid, owner, busy}); end
    checks++; if (mem_addr !== 32'h0000_2000 || mem_wdata !== 32'h1234_5678 || mem_wstrb !== 4'hF) begin errors++; $display("FAIL wr_bus: got %h %h %h expected 00002000 12345678 f", mem_addr, mem_wdata, mem_wstrb); end
    mem_ready = 1'b1;
    tick();
    checks++; if ({wr_ready, rd_ready, mem_valid} !== 3'b100) begin errors++; $display("FAIL wr_pulse: got %b expected 100", {wr_ready, rd_ready, mem_valid}); end
    mem_ready = 1'b0; wr_req = 1'b0;
    tick();
    checks++; if ({wr_ready, rd_ready, busy} !== 3'b000) begin errors++; $display("FAIL wr_done: got %b expected 000", {wr_ready, rd_ready, busy}); end
    checks++; if (dut.wr_run_q !== 4'd0) begin errors++; $display("FAIL wr_run_solo: got %0d expected 0", dut.wr_run_q); end
  endtask

  task automatic test_contention();
    logic [5:0] exp_wr;
    logic [3:0] exp_run [6];
    exp_wr = 6'b011011;
    exp_run[0] = 4'd1; exp_run[1] = 4'd2; exp_run[2] = 4'd0;
    exp_run[3] = 4'd1; exp_run[4] = 4'd2; exp_run[5] = 4'd0;
    rd_req = 1'b1; rd_addr = 32'h0000_5000;
    wr_req = 1'b1; wr_addr = 32'h0000_6000; wr_data = 32'h0BAD_CAFE; wr_strb = 4'hC;
    mem_ready = 1'b1; mem_rdata = 32'h5555_AAAA;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++; if ({mem_valid, owner} !== {1'b1, exp_wr[i], ~exp_wr[i]}) begin errors++; $display("FAIL cont_grant%0d: got %b expected %b", i, {mem_valid, owner}, {1'b1, exp_wr[i], ~exp_wr[i]}); end
      checks++; if (dut.wr_run_q !== exp_run[i]) begin errors++; $display("FAIL cont_wr_run%0d: got %0d expected %0d", i, dut.wr_run_q, exp_run[i]); end
      tick();
      checks++; if ({wr_ready, rd_ready} !== {exp_wr[i], ~exp_wr[i]}) begin errors++; $display("FAIL cont_pulse%0d: got %b expected %b", i, {wr_ready, rd_ready}, {exp_wr[i], ~exp_wr[i]}); end
      tick();
    end
    rd_req = 1'b0; wr_req = 1'b0; mem_ready = 1'b0; mem_rdata = '0;
    tick();
    checks++; if ({mem_valid, busy} !== 2'b00) begin errors++; $display("FAIL cont_quiet: got %b expected 00", {mem_valid, busy}); end
  endtask

  task automatic test_bus_stall();
    wr_req = 1'b1; wr_addr = 32'h0000_3000; wr_data = 32'hA5A5_A5A5; wr_strb = 4'h3;
    tick();
    wr_addr = 32'h0000_4444; wr_data = 32'hFFFF_FFFF; wr_strb = 4'hF;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++; if (mem_addr !== 32'h0000_3000 || mem_wdata !== 32'hA5A5_A5A5 || mem_wstrb !== 4'h3 || mem_valid !== 1'b1 || wr_ready !== 1'b0) begin errors++; $display("FAIL stall_hold%0d: got %h %h %h v%b r%b expected 00003000 a5a5a5a5 3 v1 r0", i, mem_addr, mem_wdata, mem_wstrb, mem_valid, wr_ready); end
    end
    mem_ready = 1'b1;
    tick();
    checks++; if ({wr_ready, mem_valid} !== 2'b10) begin errors++; $display("FAIL stall_pulse: got %b expected 10", {wr_ready, mem_valid}); end
    mem_ready = 1'b0; wr_req = 1'b0;
    tick();
    checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL stall_single_pulse: got %b expected 0", wr_ready); end
    tick();
  endtask

  task automatic test_enb_gating();
    enb = 1'b0; rd_req = 1'b1; wr_req = 1'b1; rd_addr = 32'h0000_7000;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if ({mem_valid, busy} !== 2'b00) begin errors++; $display("FAIL enb_block%0d: got %b expected 00", i, {mem_valid, busy}); end
    end
    wr_req = 1'b0; enb = 1'b1;
    tick();
    checks++; if ({mem_valid, owner} !== 3'b101) begin errors++; $display("FAIL enb_rd_grant: got %b expected 101", {mem_valid, owner}); end
    enb = 1'b0;
    tick();
    mem_ready = 1'b1; mem_rdata = 32'hCAFE_F00D;
    tick();
    checks++; if (rd_ready !== 1'b1 || rd_data !== 32'hCAFE_F00D) begin errors++; $display("FAIL enb_rd_complete: got %b %h expected 1 cafef00d", rd_ready, rd_data); end
    mem_ready = 1'b0;
    tick(); tick(); tick();
    checks++; if ({mem_valid, busy, rd_ready} !== 3'b000) begin errors++; $display("FAIL enb_no_regrant: got %b expected 000", {mem_valid, busy, rd_ready}); end
    enb = 1'b1;
    tick();
    checks++; if ({mem_valid, owner} !== 3'b101) begin errors++; $display("FAIL enb_resume: got %b expected 101", {mem_valid, owner}); end
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0; rd_req = 1'b0;
    tick(); tick();
  endtask

  task automatic test_reset_midop();
    wr_req = 1'b1; wr_addr = 32'h0000_8000; wr_data = 32'h0F0F_0F0F; wr_strb = 4'h1;
    tick();
    tick();
    checks++; if ({mem_valid, owner, busy} !== 4'b1101) begin errors++; $display("FAIL rst_pre: got %b expected 1101", {mem_valid, owner, busy}); end
    #2 resetn = 1'b0;
    #1;
    checks++; if ({mem_valid, owner, busy} !== 4'b0000) begin errors++; $display("FAIL rst_async: got %b expected 0000", {mem_valid, owner, busy}); end
    mem_ready = 1'b1;
    tick();
    checks++; if ({wr_ready, rd_ready, mem_valid} !== 3'b000) begin errors++; $display("FAIL rst_no_pulse: got %b expected 000", {wr_ready, rd_ready, mem_valid}); end
    mem_ready = 1'b0;
    @(negedge clk); resetn = 1'b1;
    tick();
    checks++; if ({mem_valid, owner, busy} !== 4'b1101 || mem_addr !== 32'h0000_8000) begin errors++; $display("FAIL rst_regrant: got %b %h expected 1101 00008000", {mem_valid, owner, busy}, mem_addr); end
    mem_ready = 1'b1;
    tick();
    checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL rst_complete: got %b expected 1", wr_ready); end
    mem_ready = 1'b0; wr_req = 1'b0;
    tick(); tick();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_single_write();
    test_contention();
    test_bus_stall();
    test_enb_gating();
    test_reset_midop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
